// File: rtl/key_event_arbiter.sv
// Keypad event capture FIFO with a round-robin two-consumer pop arbiter.
// Define KEY_REPEAT_FILTER_EN to discard captures that repeat the last pushed code.
module key_event_arbiter #(
    parameter int DEPTH        = 4,
    parameter int CLEAR_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_key,
    input  logic [3:0] key,
    output logic       kp_clear,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic [3:0] key_out,
    output logic [4:0] count,
    output logic       overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, CLEAR, WAIT} state_t;

    state_t        state, state_nxt;
    logic [3:0]    clr_cnt;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          last_gnt;
    logic          capture, full, dup, push, drop, pop, sel;

    assign capture = (state == IDLE) && valid_key;
    assign full    = (count == 5'(DEPTH));

`ifdef KEY_REPEAT_FILTER_EN
    logic [3:0] last_code;
    logic       last_vld;

    assign dup = last_vld && (key == last_code);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_vld  <= 1'b0;
            last_code <= '0;
        end else if (push) begin
            last_vld  <= 1'b1;
            last_code <= key;
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign push = capture && !dup && !full;
    assign drop = capture && !dup && full;
    assign pop  = (count != '0) && (req != '0);

    // With both requesting, favour the consumer not granted last time.
    always_comb begin
        if (req == 2'b11) sel = ~last_gnt;
        else              sel = req[1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid_key) state_nxt = CLEAR;
            CLEAR:   if (clr_cnt == 4'(CLEAR_CYCLES - 1)) state_nxt = WAIT;
            WAIT:    if (!valid_key) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        kp_clear = (state != CLEAR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              clr_cnt <= '0;
        else if (state != CLEAR) clr_cnt <= '0;
        else                     clr_cnt <= clr_cnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= key;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            grant    <= '0;
            key_out  <= '0;
            last_gnt <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
            if (pop) begin
                grant    <= sel ? 2'b10 : 2'b01;
                key_out  <= mem[rd_ptr];
                last_gnt <= sel;
            end else begin
                grant   <= '0;
                key_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_key_event_arbiter.sv
// Randomized and directed bench for key_event_arbiter against a queue-based reference model.
module tb_key_event_arbiter;

    localparam int DEPTH        = 4;
    localparam int CLEAR_CYCLES = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       valid_key = 1'b0;
    logic [3:0] key = '0;
    logic       kp_clear;
    logic [1:0] req = '0;
    logic [1:0] grant;
    logic [3:0] key_out;
    logic [4:0] count;
    logic       overflow;

    key_event_arbiter #(.DEPTH(DEPTH), .CLEAR_CYCLES(CLEAR_CYCLES)) dut (
        .clk(clk), .reset(reset), .valid_key(valid_key), .key(key),
        .kp_clear(kp_clear), .req(req), .grant(grant), .key_out(key_out),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue contents plus capture-sequence bookkeeping.
    logic [3:0] q[$];
    int         m_clr_left;
    bit         m_waiting;
    int         m_last;
    bit         m_ovf;
    logic [1:0] m_grant;
    logic [3:0] m_keyout;
    bit         m_code_vld;
    logic [3:0] m_code;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_clr_left = 0;
        m_waiting  = 1'b0;
        m_last     = 1;
        m_ovf      = 1'b0;
        m_grant    = '0;
        m_keyout   = '0;
        m_code_vld = 1'b0;
        m_code     = '0;
    endtask

    task automatic model_step(input logic vk, input logic [3:0] k, input logic [1:0] r);
        int  cnt0;
        int  winner;
        bit  repeat_code;
        cnt0     = q.size();
        m_grant  = '0;
        m_keyout = '0;
        if (cnt0 > 0 && r != 2'b00) begin
            if (r == 2'b11) winner = 1 - m_last;
            else            winner = r[1] ? 1 : 0;
            m_keyout = q.pop_front();
            m_grant  = (winner == 1) ? 2'b10 : 2'b01;
            m_last   = winner;
        end
        if (m_clr_left == 0 && !m_waiting && vk) begin
            repeat_code = 1'b0;
`ifdef KEY_REPEAT_FILTER_EN
            repeat_code = m_code_vld && (m_code == k);
`endif
            if (!repeat_code) begin
                if (cnt0 == DEPTH) m_ovf = 1'b1;
                else begin
                    q.push_back(k);
                    m_code_vld = 1'b1;
                    m_code     = k;
                end
            end
            m_clr_left = CLEAR_CYCLES;
        end else if (m_clr_left > 0) begin
            m_clr_left--;
            if (m_clr_left == 0) m_waiting = 1'b1;
        end else if (m_waiting && !vk) begin
            m_waiting = 1'b0;
        end
    endtask

    task automatic check_all();
        check("grant",    32'(grant),    32'(m_grant));
        check("key_out",  32'(key_out),  32'(m_keyout));
        check("count",    32'(count),    32'(q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("kp_clear", 32'(kp_clear), 32'(m_clr_left == 0));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(valid_key, key, req);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        valid_key = 1'b0;
        req       = '0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;
    endtask

    task automatic capture(input logic [3:0] code);
        valid_key = 1'b1;
        key       = code;
        cycle();
        valid_key = 1'b0;
        repeat (CLEAR_CYCLES + 2) cycle();
    endtask

    task automatic drain(input logic [1:0] r);
        req = r;
        repeat (DEPTH + 2) cycle();
        req = '0;
        cycle();
    endtask

    initial begin
        model_reset();
        do_reset();

        // Two-cycle valid_key yields one push and one clear pulse.
        valid_key = 1'b1;
        key       = 4'b0110;
        repeat (2) cycle();
        valid_key = 1'b0;
        repeat (CLEAR_CYCLES + 3) cycle();
        drain(2'b01);

        // Round-robin over a held dual request.
        do_reset();
        capture(4'd3);
        capture(4'd5);
        capture(4'd9);
        drain(2'b11);

        // Overflow on the fifth capture.
        do_reset();
        for (int i = 1; i <= 5; i++) capture(4'(i));
        drain(2'b10);

        // Simultaneous push and pop at count 2.
        do_reset();
        capture(4'd1);
        capture(4'd2);
        valid_key = 1'b1;
        key       = 4'd7;
        req       = 2'b01;
        cycle();
        valid_key = 1'b0;
        req       = '0;
        repeat (CLEAR_CYCLES + 2) cycle();
        drain(2'b01);

        // Repeated codes (filtered only when the macro is defined).
        do_reset();
        capture(4'd2);
        capture(4'd2);
        capture(4'd4);
        capture(4'd2);
        drain(2'b11);

        // Asynchronous reset in the second clear cycle with three queued events.
        do_reset();
        capture(4'd1);
        capture(4'd2);
        valid_key = 1'b1;
        key       = 4'd3;
        cycle();
        valid_key = 1'b0;
        cycle();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Random traffic with a small key alphabet to provoke repeats and overflow.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            valid_key = ($urandom_range(0, 2) == 0);
            key       = 4'($urandom_range(0, 3));
            req       = ($urandom_range(0, 9) < 5) ? 2'b00 : 2'($urandom_range(1, 3));
            cycle();
            if (i == 1500) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
